// File: rtl/nlane_serial_master.sv
// N-lane serial link transmitter: one DATA_WIDTH word per handshake, framed by cs_n
// and shifted out LANES bits per sclk beat, with sclk divided down from clk.
module nlane_serial_master #(
  parameter int DATA_WIDTH = 64,
  parameter int LANES      = 2,
  parameter int CLK_DIV    = 2,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic [LANES-1:0]      dl,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS  = DATA_WIDTH / LANES;
  localparam int HALVES = 2 * BEATS;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(HALVES);

  localparam logic [DIV_W-1:0]  DIV_LAST        = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST       = HALF_W'(HALVES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST_SHIFT = HALF_W'(HALVES - 2);

  if (LANES < 1 || LANES > DATA_WIDTH || (DATA_WIDTH % LANES) != 0 || CLK_DIV < 1)
  begin : g_param_check
    $error("nlane_serial_master: DATA_WIDTH must be a multiple of LANES and CLK_DIV >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  function automatic logic [LANES-1:0] first_beat(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[LANES-1:0] : w[DATA_WIDTH-1 -: LANES];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> LANES) : (w << LANES);
  endfunction

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [HALF_W-1:0]       half_q, half_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic [LANES-1:0]        dl_q, dl_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    div_wrap;
  logic [DATA_WIDTH-1:0]   shreg_next;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    dl_d       = dl_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_wrap   = (div_q == DIV_LAST);
    shreg_next = advance(shreg_q);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_SETUP;
          div_d      = '0;
          shreg_d    = in_data;
          dl_d       = first_beat(in_data);
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (div_wrap) begin
          state_d = S_SHIFT;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_wrap) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            state_d = S_HOLD;
          end else begin
            half_d = half_q + 1'b1;
            sclk_d = ~sclk_q;
            // Even half-periods are high, so leaving one is a fall; the final fall keeps the last beat.
            if (!half_q[0] && half_q != HALF_LAST_SHIFT) begin
              shreg_d = shreg_next;
              dl_d    = first_beat(shreg_next);
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_wrap) begin
          state_d = S_GAP;
          div_d   = '0;
          cs_n_d  = 1'b1;
          dl_d    = '0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_wrap) begin
          state_d    = S_IDLE;
          div_d      = '0;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      // NOTE: the shift register is reset as well; it is one word wide, and a clean value
      // keeps dl deterministic even though it is reloaded on every accept.
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dl_q       <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      dl_q       <= dl_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign dl       = dl_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
